givens_reconstruct: RTL and testbench
=====================================

GIVENS_RECONSTRUCT -- requirements
Module: givens_reconstruct

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the width of every matrix element and angle word (signed two's complement; 256 = 1.0 for matrix data).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1, the reset: asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to reconstruct; sampled only in IDLE.
REQ-005 SHALL have port r_matrix, input, [DATA_WIDTH-1:0] [0:2][0:2], upper-triangular R factor.
REQ-006 SHALL have port theta_in, input, [DATA_WIDTH-1:0] [0:2], forward Givens angles (theta_in[0] rows 1/2 col 0; [1] rows 0/1 col 0; [2] rows 1/2 col 1).
REQ-007 SHALL have port op_matrix, output, signed [DATA_WIDTH-1:0] [0:2][0:2], reconstructed matrix A = Q*R.
REQ-008 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 SHALL have ports start_rot (output, 1), x0_rot, y0_rot and theta_rot (outputs, DATA_WIDTH each), the request side of the external gain-compensated rotating CORDIC.
REQ-011 SHALL have ports valid_rot (input, 1), x_rot and y_rot (inputs, DATA_WIDTH each), the result side of that CORDIC.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE.
REQ-013 In IDLE, start=1 at an edge SHALL copy r_matrix into a 3x3 working register and theta_in into angle registers, clear the step/column counters, and go to ISSUE.
REQ-014 SHALL apply 3 inverse rotations in this order: step 0 on rows 1/2 with -theta_in[2]; step 1 on rows 0/1 with -theta_in[1]; step 2 on rows 1/2 with -theta_in[0].
REQ-015 Each step SHALL process columns 0, 1 and 2 in order, giving 9 CORDIC calls total.
REQ-016 For one call, the operands SHALL be x0_rot = W[upper row][col], y0_rot = W[lower row][col] and theta_rot = negated angle.
REQ-017 Angle negation SHALL be two's complement, except that the most-negative value SHALL saturate to the most-positive value.
REQ-018 ISSUE SHALL last exactly 1 cycle, with start_rot=1 and operands stable; the block SHALL then go to WAIT.
REQ-019 x0_rot, y0_rot and theta_rot SHALL hold their values from ISSUE until valid_rot is sampled.
REQ-020 In WAIT, valid_rot=1 at an edge SHALL write x_rot to W[upper][col] and y_rot to W[lower][col] and advance the counters.
REQ-021 After that write, the block SHALL go to ISSUE if calls remain, else to DONE; WAIT SHALL have no timeout.
REQ-022 valid_rot SHALL be ignored outside WAIT, and start SHALL be ignored outside IDLE.
REQ-023 DONE SHALL last 1 cycle: op_matrix is loaded from W, done=1, and the block goes to IDLE.
REQ-024 op_matrix SHALL hold its value until the next DONE.
REQ-025 With CORDIC latency L (start_rot edge to valid_rot sampled), done SHALL rise exactly 9*(L+1)+1 cycles after start is sampled.
REQ-026 start=1 in the same cycle as DONE SHALL be ignored; start is accepted from IDLE on the following cycle.
REQ-027 start_rot SHALL never be high for two consecutive cycles.
REQ-028 No scaling, rounding or saturation of x_rot/y_rot SHALL be applied; values SHALL be written back as received.

Reset
REQ-029 RST=1 SHALL immediately force IDLE and set start_rot=0, done=0, busy=0, op_matrix=0, working/angle registers=0 and x0_rot/y0_rot/theta_rot=0, including mid-operation.
REQ-030 A valid_rot arriving after reset releases SHALL be ignored, because the block is then in IDLE.

Verification
REQ-031 Identity test: stub CORDIC with L=4, r_matrix=256*I, all thetas 0 -> 9 start_rot pulses; done 46 cycles after start; op_matrix=256*I; busy low afterward.
REQ-032 Operand-order test: thetas {10,20,30}, R filled with distinct values -> call 1 has x0=R[1][0], y0=R[2][0], theta=-30; call 4 has rows 0/1 col 0, theta=-20; call 7 has rows 1/2 col 0, theta=-10.
REQ-033 Angle saturation test: theta_in[2]=32'h8000_0000 -> theta_rot=32'h7FFF_FFFF on calls 1-3.
REQ-034 Variable-latency test: stub latency randomized 1-20 per call, with spurious valid_rot pulses in ISSUE/IDLE -> results match golden A=Q*R model within +/-2 LSB; spurious pulses have no effect.
REQ-035 Reset test: RST asserted during call 5 WAIT -> outputs zero in the same cycle; a later valid_rot is ignored; a new start gives a correct full result.
REQ-036 Back-to-back test: start held high continuously -> second run begins one cycle after DONE; each op_matrix is correct.

Source files
------------

// File: rtl/givens_reconstruct.sv
// givens_reconstruct: rebuilds A = Q*R from an upper-triangular R factor and the three
// forward Givens angles by replaying the inverse rotations through an external rotating
// CORDIC, one column element pair per call (3 steps x 3 columns = 9 calls).
`timescale 1ns/1ps
module givens_reconstruct #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic        [DATA_WIDTH-1:0] r_matrix  [0:2][0:2],
  input  logic        [DATA_WIDTH-1:0] theta_in  [0:2],
  output logic signed [DATA_WIDTH-1:0] op_matrix [0:2][0:2],
  output logic                         done,
  output logic                         busy,
  output logic                         start_rot,
  output logic        [DATA_WIDTH-1:0] x0_rot,
  output logic        [DATA_WIDTH-1:0] y0_rot,
  output logic        [DATA_WIDTH-1:0] theta_rot,
  input  logic                         valid_rot,
  input  logic        [DATA_WIDTH-1:0] x_rot,
  input  logic        [DATA_WIDTH-1:0] y_rot
);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam word_t MostNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam word_t MostPos = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  state_e     r_state, w_state_d;
  word_t      r_w     [0:2][0:2];
  word_t      w_w_d   [0:2][0:2];
  word_t      r_ang   [0:2];
  word_t      w_ang_d [0:2];
  logic [1:0] r_step, w_step_d;
  logic [1:0] r_col, w_col_d;
  logic [1:0] w_up, w_lo, w_up_n, w_lo_n;
  word_t      w_ang_sel;
  word_t      r_x0, r_y0, r_th;
  word_t      w_x0_d, w_y0_d, w_th_d;
  logic signed [DATA_WIDTH-1:0] r_op [0:2][0:2];
  logic       w_last;

  // Two's complement negate; the most-negative angle has no positive twin, so clamp it.
  function automatic word_t neg_sat(input word_t a);
    if (a == MostNeg) return MostPos;
    return word_t'(-a);
  endfunction

  // Step 1 works on rows 0/1, steps 0 and 2 on rows 1/2.
  function automatic logic [1:0] upper_row(input logic [1:0] step);
    return (step == 2'd1) ? 2'd0 : 2'd1;
  endfunction

  assign w_last = (r_step == 2'd2) && (r_col == 2'd2);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = StIssue;
      StIssue: w_state_d = StWait;
      StWait:  if (valid_rot) w_state_d = w_last ? StDone : StIssue;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    start_rot = (r_state == StIssue);
    busy      = (r_state != StIdle);
    done      = (r_state == StDone);
  end

  // Working matrix, angles and counters: load on start, write back on each CORDIC result
  always_comb begin
    w_w_d    = r_w;
    w_ang_d  = r_ang;
    w_step_d = r_step;
    w_col_d  = r_col;
    w_up     = upper_row(r_step);
    w_lo     = w_up + 2'd1;
    if (r_state == StIdle && start) begin
      w_w_d    = r_matrix;
      w_ang_d  = theta_in;
      w_step_d = 2'd0;
      w_col_d  = 2'd0;
    end else if (r_state == StWait && valid_rot) begin
      w_w_d[w_up][r_col] = x_rot;
      w_w_d[w_lo][r_col] = y_rot;
      if (r_col == 2'd2) begin
        w_col_d  = 2'd0;
        w_step_d = r_step + 2'd1;
      end else begin
        w_col_d = r_col + 2'd1;
      end
    end
  end

  // Operands for the next call, taken from the post-update matrix and counters
  always_comb begin
    w_up_n = upper_row(w_step_d);
    w_lo_n = w_up_n + 2'd1;
    case (w_step_d)
      2'd0:    w_ang_sel = w_ang_d[2];
      2'd1:    w_ang_sel = w_ang_d[1];
      default: w_ang_sel = w_ang_d[0];
    endcase
    w_x0_d = w_w_d[w_up_n][w_col_d];
    w_y0_d = w_w_d[w_lo_n][w_col_d];
    w_th_d = neg_sat(w_ang_sel);
  end

  // Datapath registers; operands only change on entry to ISSUE so they hold through WAIT
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) begin
        r_ang[i] <= '0;
        for (int j = 0; j < 3; j++) begin
          r_w[i][j]  <= '0;
          r_op[i][j] <= '0;
        end
      end
      r_step <= 2'd0;
      r_col  <= 2'd0;
      r_x0   <= '0;
      r_y0   <= '0;
      r_th   <= '0;
    end else begin
      r_w    <= w_w_d;
      r_ang  <= w_ang_d;
      r_step <= w_step_d;
      r_col  <= w_col_d;
      if (w_state_d == StIssue) begin
        r_x0 <= w_x0_d;
        r_y0 <= w_y0_d;
        r_th <= w_th_d;
      end
      // Result is presented during the DONE cycle and held until the next one
      if (w_state_d == StDone) begin
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            r_op[i][j] <= w_w_d[i][j];
          end
        end
      end
    end
  end

  assign x0_rot    = r_x0;
  assign y0_rot    = r_y0;
  assign theta_rot = r_th;
  assign op_matrix = r_op;

endmodule

// File: tb/tb_givens_reconstruct.sv
// Bench for givens_reconstruct: directed runs with hand-computed results, a stub CORDIC
// (angle word: full turn = 2^32) and a scoreboard monitor checking op_matrix on done.
`timescale 1ns/1ps
module tb_givens_reconstruct;
  localparam int DW = 32;
  typedef logic [0:8][DW-1:0] mat_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0;
  logic        [DW-1:0] r_matrix  [0:2][0:2];
  logic        [DW-1:0] theta_in  [0:2];
  logic signed [DW-1:0] op_matrix [0:2][0:2];
  logic done, busy, start_rot, valid_rot;
  logic [DW-1:0] x0_rot, y0_rot, theta_rot, x_rot, y_rot;

  givens_reconstruct #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .r_matrix(r_matrix), .theta_in(theta_in),
    .op_matrix(op_matrix), .done(done), .busy(busy), .start_rot(start_rot),
    .x0_rot(x0_rot), .y0_rot(y0_rot), .theta_rot(theta_rot),
    .valid_rot(valid_rot), .x_rot(x_rot), .y_rot(y_rot)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, cyc_start = 0;
  int done_cnt = 0, last_done_cyc = 0;
  int rot_pulses = 0, rot_double = 0, last_rot_cyc = 0;
  bit prev_rot = 0;
  mat_t  exp_q[$];
  string name_q[$];

  // Stub controls and call log
  int lat_fixed = 4;
  bit lat_rand = 0, spur_en = 0, inject = 0;
  int call_n = 0;
  logic [DW-1:0] log_x [0:8];
  logic [DW-1:0] log_y [0:8];
  logic [DW-1:0] log_t [0:8];
  bit  pend = 0;
  int  cnt = 0;
  real px = 0.0, py = 0.0, ph = 0.0;
  longint rx, ry;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic mat_t mk(input int v [9]);
    mat_t m;
    for (int i = 0; i < 9; i++) m[i] = v[i];
    return m;
  endfunction

  function automatic longint rnd(input real r);
    if (r >= 0.0) return longint'($rtoi(r + 0.5));
    return -longint'($rtoi(-r + 0.5));
  endfunction

  function automatic string fmt_exp(input mat_t m);
    string s = "";
    for (int i = 0; i < 9; i++) s = {s, $sformatf("%0d ", $signed(m[i]))};
    return s;
  endfunction

  function automatic string fmt_op();
    string s = "";
    for (int i = 0; i < 9; i++) s = {s, $sformatf("%0d ", op_matrix[i/3][i%3])};
    return s;
  endfunction

  // Number of outputs that are not zero
  function automatic longint nonzero_outs();
    longint n = 0;
    n += longint'(start_rot) + longint'(done) + longint'(busy);
    n += longint'(x0_rot != 0) + longint'(y0_rot != 0) + longint'(theta_rot != 0);
    for (int i = 0; i < 9; i++) n += longint'(op_matrix[i/3][i%3] != 0);
    return n;
  endfunction

  task automatic set_in(input mat_t r, input logic [DW-1:0] a0, a1, a2);
    for (int i = 0; i < 9; i++) r_matrix[i/3][i%3] = r[i];
    theta_in[0] = a0;
    theta_in[1] = a1;
    theta_in[2] = a2;
  endtask

  task automatic wait_done(input string nm, input int d0, input int budget);
    for (int k = 0; k < budget && done_cnt == d0; k++) begin
      @(negedge CLK); #1;
    end
    chk({nm, " done seen"}, longint'(done_cnt != d0), 1);
  endtask

  task automatic wait_rot(input string nm, input int r0, input int budget);
    for (int k = 0; k < budget && rot_pulses == r0; k++) begin
      @(negedge CLK); #1;
    end
    chk({nm, " start_rot seen"}, longint'(rot_pulses != r0), 1);
  endtask

  task automatic run(input mat_t e, input string nm, input int budget);
    int d0;
    exp_q.push_back(e);
    name_q.push_back(nm);
    d0 = done_cnt;
    call_n = 0;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0; cyc_start = cyc;
    wait_done(nm, d0, budget);
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Stub rotating CORDIC: samples start_rot at negedge, answers L cycles later
  initial begin
    valid_rot = 1'b0;
    x_rot = '0;
    y_rot = '0;
    forever begin
      @(negedge CLK);
      valid_rot = 1'b0;
      if (RST) begin
        pend = 0;
      end else begin
        if (pend) begin
          if (cnt <= 1) begin
            rx = rnd(px * $cos(ph) - py * $sin(ph));
            ry = rnd(px * $sin(ph) + py * $cos(ph));
            x_rot = rx[DW-1:0];
            y_rot = ry[DW-1:0];
            valid_rot = 1'b1;
            pend = 0;
          end else begin
            cnt--;
          end
        end
        if (start_rot) begin
          if (call_n < 9) begin
            log_x[call_n] = x0_rot;
            log_y[call_n] = y0_rot;
            log_t[call_n] = theta_rot;
          end
          call_n++;
          px = $itor($signed(x0_rot));
          py = $itor($signed(y0_rot));
          ph = $itor($signed(theta_rot)) * 6.283185307179586 / 4294967296.0;
          pend = 1;
          cnt = lat_rand ? int'($urandom_range(1, 20)) : lat_fixed;
          if (spur_en && $urandom_range(0, 1) == 1) begin
            valid_rot = 1'b1;
            x_rot = $urandom;
            y_rot = $urandom;
          end
        end else if (!busy && spur_en && $urandom_range(0, 2) == 0) begin
          valid_rot = 1'b1;
          x_rot = $urandom;
          y_rot = $urandom;
        end
      end
      if (inject) begin
        valid_rot = 1'b1;
        x_rot = 32'h1234;
        y_rot = 32'h5678;
      end
    end
  end

  // Monitor: counts start_rot pulses and checks each done against the scoreboard
  initial begin
    mat_t  em;
    string nm;
    bit    bad;
    longint d;
    forever begin
      @(negedge CLK);
      if (start_rot) begin
        if (prev_rot) rot_double++;
        rot_pulses++;
        last_rot_cyc = cyc;
      end
      prev_rot = start_rot;
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard: done with no expected result, got %s", fmt_op());
        end else begin
          em = exp_q.pop_front();
          nm = name_q.pop_front();
          bad = 0;
          for (int i = 0; i < 9; i++) begin
            d = longint'(op_matrix[i/3][i%3]) - longint'($signed(em[i]));
            if (d > 2 || d < -2) bad = 1;
          end
          if (bad) $display("FAIL result %s: got %s expected %s", nm, fmt_op(), fmt_exp(em));
          else n_pass++;
        end
      end
    end
  end

  initial begin
    mat_t r_id, r2, r3, r3_exp, r4, r4_exp;
    r_id   = mk('{256, 0, 0, 0, 256, 0, 0, 0, 256});
    r2     = mk('{11, 12, 13, 21, 22, 23, 31, 32, 33});
    r3     = mk('{1, 2, 3, 4, 5, 6, 7, 8, 9});
    r3_exp = mk('{1, 2, 3, -4, -5, -6, -7, -8, -9});
    r4     = mk('{100, 200, 300, 0, 400, 500, 0, 0, 600});
    // -90 deg on rows 1/2, then -90 deg on rows 0/1: upper <- lower, lower <- -upper
    r4_exp = mk('{0, 0, 600, -100, -200, -300, 0, -400, -500});
    set_in(r_id, 0, 0, 0);

    repeat (3) @(negedge CLK);
    chk("outputs in reset", nonzero_outs(), 0);
    RST = 1'b0;

    // Identity, L=4
    lat_fixed = 4;
    rot_pulses = 0;
    run(r_id, "identity", 100);
    chk("identity start_rot pulses", rot_pulses, 9);
    // Counted to the clock edge at which done is first sampled high
    chk("identity done latency", last_done_cyc + 1 - cyc_start, 46);
    @(negedge CLK); #1;
    chk("identity busy after done", longint'(busy), 0);

    // Operand ordering; tiny angles leave the data unchanged
    set_in(r2, 10, 20, 30);
    run(r2, "order", 100);
    chk("call1 x0", longint'($signed(log_x[0])), 21);
    chk("call1 y0", longint'($signed(log_y[0])), 31);
    chk("call1 theta", longint'($signed(log_t[0])), -30);
    chk("call4 x0", longint'($signed(log_x[3])), 11);
    chk("call4 y0", longint'($signed(log_y[3])), 21);
    chk("call4 theta", longint'($signed(log_t[3])), -20);
    chk("call7 x0", longint'($signed(log_x[6])), 21);
    chk("call7 y0", longint'($signed(log_y[6])), 31);
    chk("call7 theta", longint'($signed(log_t[6])), -10);

    // Angle saturation: -(-180 deg) clamps to just under +180 deg
    set_in(r3, 0, 0, 32'h8000_0000);
    run(r3_exp, "saturate", 100);
    for (int i = 0; i < 3; i++)
      chk($sformatf("sat call%0d theta", i + 1), longint'(log_t[i]), 64'h7FFF_FFFF);

    // Random latency with spurious valid_rot in ISSUE/IDLE
    set_in(r4, 0, 32'h4000_0000, 32'h4000_0000);
    lat_rand = 1;
    spur_en = 1;
    run(r4_exp, "varlat a", 400);
    repeat (10) @(negedge CLK);
    #1;
    chk("busy stays low with spurious valid", longint'(busy), 0);
    run(r4_exp, "varlat b", 400);
    spur_en = 0;
    lat_rand = 0;
    repeat (2) @(negedge CLK);

    // Reset during the WAIT of call 5
    lat_fixed = 6;
    rot_pulses = 0;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    for (int k = 0; k < 200 && rot_pulses < 5; k++) begin
      @(negedge CLK); #1;
    end
    chk("reached call 5", rot_pulses, 5);
    @(negedge CLK); #1;
    chk("busy before reset", longint'(busy), 1);
    RST = 1'b1;
    #1;
    chk("outputs zero in reset", nonzero_outs(), 0);
    @(negedge CLK); #2;
    RST = 1'b0;
    inject = 1;
    @(negedge CLK); #2;
    inject = 0;
    repeat (3) @(negedge CLK);
    #1;
    chk("late valid_rot ignored", nonzero_outs(), 0);
    lat_fixed = 3;
    run(r4_exp, "after reset", 200);

    // Back-to-back with start held high
    lat_fixed = 2;
    exp_q.push_back(r4_exp);
    name_q.push_back("b2b first");
    exp_q.push_back(r4_exp);
    name_q.push_back("b2b second");
    begin
      int d0, r0;
      d0 = done_cnt;
      @(negedge CLK); start = 1'b1;
      wait_done("b2b first", d0, 200);
      r0 = rot_pulses;
      d0 = done_cnt;
      wait_rot("b2b restart", r0, 10);
      chk("b2b done to next start_rot", last_rot_cyc - last_done_cyc, 2);
      start = 1'b0;
      wait_done("b2b second", d0, 200);
    end
    repeat (3) @(negedge CLK);
    chk("scoreboard drained", exp_q.size(), 0);
    chk("no back-to-back start_rot", rot_double, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
